// File: rtl/time_keeper.sv
// time_keeper: BCD time-of-day counter, alarm time register, button-driven
// set-mode state machine and alarm ring timer for the digital clock.
// All outputs come straight from registers; bytes are packed BCD {tens, units}.
module time_keeper #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int RING_SECS     = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       target_sel,
    input  logic       alarm_en,
    output logic [7:0] clockHour,
    output logic [7:0] clockMin,
    output logic [7:0] clockSec,
    output logic [7:0] alarmHour,
    output logic [7:0] alarmMin,
    output logic [1:0] setting,
    output logic       ring
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int RW = $clog2(RING_SECS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic          target_q, target_d;     // 0 = clock, 1 = alarm
    logic          mode_prev_q, inc_prev_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    hour_q, hour_d;
    logic [7:0]    min_q, min_d;
    logic [7:0]    sec_q, sec_d;
    logic [7:0]    ahour_q, ahour_d;
    logic [7:0]    amin_q, amin_d;
    logic          ring_q, ring_d;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;

    logic mode_press, inc_press, clock_set, tick, dismiss, do_mode, do_inc;
    logic alarm_hit;

    // BCD increment that wraps to 00 after max_v; units carry into tens.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == max_v)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    assign mode_press = mode_btn & ~mode_prev_q;
    assign inc_press  = inc_btn & ~inc_prev_q;
    // Setting the clock freezes the prescaler and the seconds.
    assign clock_set  = (state_q != RUN) && !target_q;
    assign tick       = (presc_q == PRESC_LAST) && !clock_set;
    // Any press while ringing only silences the ring.
    assign dismiss    = ring_q && (mode_press || inc_press);
    assign do_mode    = mode_press && !ring_q;
    assign do_inc     = inc_press && !mode_press && !ring_q;

    // Next-state for prescaler, time of day, alarm time, FSM and ring timer.
    always_comb begin
        // NOTE: every next-state value gets a default first so no path infers a latch.
        state_d    = state_q;
        target_d   = target_q;
        presc_d    = presc_q + PW'(1);
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        ahour_d    = ahour_q;
        amin_d     = amin_q;
        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
        alarm_hit  = 1'b0;

        if (tick) begin
            presc_d = '0;
            sec_d   = bcd_inc(sec_q, 8'h59);
            if (sec_q == 8'h59) begin
                min_d = bcd_inc(min_q, 8'h59);
                if (min_q == 8'h59)
                    hour_d = bcd_inc(hour_q, 8'h23);
            end
            alarm_hit = (state_q == RUN) && alarm_en && (hour_d == ahour_q) &&
                        (min_d == amin_q) && (sec_d == 8'h00);
        end

        case (state_q)
            RUN: begin
                if (do_mode) begin
                    state_d  = SET_HOUR;
                    target_d = target_sel;
                    if (!target_sel)
                        presc_d = '0;
                end
            end
            SET_HOUR: begin
                if (do_mode)
                    state_d = SET_MIN;
                else if (do_inc && target_q)
                    ahour_d = bcd_inc(ahour_q, 8'h23);
                else if (do_inc)
                    hour_d = bcd_inc(hour_q, 8'h23);
            end
            SET_MIN: begin
                if (do_mode) begin
                    state_d = RUN;
                    if (!target_q) begin
                        sec_d   = 8'h00;
                        presc_d = '0;
                    end
                end else if (do_inc && target_q)
                    amin_d = bcd_inc(amin_q, 8'h59);
                else if (do_inc)
                    min_d = bcd_inc(min_q, 8'h59);
            end
            default: state_d = RUN;
        endcase

        if (clock_set)
            presc_d = '0;

        if (dismiss || !alarm_en) begin
            ring_d     = 1'b0;
            ring_cnt_d = '0;
        end else if (ring_q && tick) begin
            ring_cnt_d = ring_cnt_q - RW'(1);
            if (ring_cnt_q == RW'(1))
                ring_d = 1'b0;
        end

        if (alarm_hit) begin
            ring_d     = 1'b1;
            ring_cnt_d = RW'(RING_SECS);
        end
    end

    // State registers; asynchronous reset to 00:00:00, RUN, silent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            target_q    <= 1'b0;
            // NOTE: button history resets to 1 so a button held through reset is not a press.
            mode_prev_q <= 1'b1;
            inc_prev_q  <= 1'b1;
            presc_q     <= '0;
            hour_q      <= 8'h00;
            min_q       <= 8'h00;
            sec_q       <= 8'h00;
            ahour_q     <= 8'h00;
            amin_q      <= 8'h00;
            ring_q      <= 1'b0;
            ring_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values together.
            state_q     <= state_d;
            target_q    <= target_d;
            mode_prev_q <= mode_btn;
            inc_prev_q  <= inc_btn;
            presc_q     <= presc_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            ahour_q     <= ahour_d;
            amin_q      <= amin_d;
            ring_q      <= ring_d;
            ring_cnt_q  <= ring_cnt_d;
        end
    end

    assign clockHour = hour_q;
    assign clockMin  = min_q;
    assign clockSec  = sec_q;
    assign alarmHour = ahour_q;
    assign alarmMin  = amin_q;
    assign setting   = state_q;
    assign ring      = ring_q;

endmodule

// File: doc/time_keeper.md
# time_keeper

Timekeeping core of the digital clock: counts BCD hours/minutes/seconds from the system clock, holds the alarm time, and runs the button-driven set-mode state machine and the alarm ring timer. Sits directly upstream of the display driver, feeding it `clockHour`/`clockMin`/`clockSec` and `alarmHour`/`alarmMin` as packed BCD bytes, with `[7:4]` the tens digit and `[3:0]` the units digit.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 50_000_000: `clk` cycles per second.
- `RING_SECS`, default 30: ring duration in seconds; minimum 1.

Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `mode_btn`, input, 1: debounced, synchronous level, active-high; cycles the set mode.
- `inc_btn`, input, 1: debounced, synchronous level, active-high; increments the field being set.
- `target_sel`, input, 1: set target; 0 = clock, 1 = alarm.
- `alarm_en`, input, 1: alarm enable.
- `clockHour`, output, 8: BCD 00–23.
- `clockMin`, output, 8: BCD 00–59.
- `clockSec`, output, 8: BCD 00–59.
- `alarmHour`, output, 8: BCD 00–23.
- `alarmMin`, output, 8: BCD 00–59.
- `setting`, output, 2: 00 = RUN, 01 = SET_HOUR, 10 = SET_MIN.
- `ring`, output, 1: alarm sounding.

## Operation
- **Press detection:** a press is a button sampled 1 while its previous sample was 0. The previous-sample registers reset to 1, so a button held through reset produces no press.
- **Prescaler:** counts 0..TICKS_PER_SEC-1 and wraps. `tick` is asserted in the cycle the count equals TICKS_PER_SEC-1.
- **FSM:**
  - RUN --mode--> SET_HOUR --mode--> SET_MIN --mode--> RUN.
  - `target_sel` is latched on the RUN→SET_HOUR transition. The latched target holds until the return to RUN.
- **RUN, on tick:**
  - Seconds +1; 59→00 carries into minutes.
  - Minutes 59→00 carries into hours.
  - Hours 23→00.
  - `inc` presses are ignored in RUN, except when they dismiss a ring.
- **SET_HOUR:** each `inc` press increments the target's hour modulo 24, with no carry.
- **SET_MIN:** each `inc` press increments the target's minute modulo 60, with no carry into hours.
- **Clock as target:**
  - The prescaler is held at 0 and seconds are frozen while in SET_HOUR or SET_MIN.
  - On SET_MIN→RUN, `clockSec` is cleared to 00 and the prescaler restarts from 0.
- **Alarm as target:** the clock keeps counting normally.
- **BCD rules:**
  - Units digits never exceed 9.
  - Hour tens digit never exceeds 2; minute and second tens digits never exceed 5.
  - Increments carry units→tens inside each byte.
- **Alarm trigger:** `ring` sets when a tick in RUN moves the clock to a time whose `clockHour`/`clockMin` equal `alarmHour`/`alarmMin` and whose seconds equal 00, with `alarm_en`=1. Manually setting the clock to the alarm time never triggers.
- **Ring timer:**
  - Loaded with RING_SECS on trigger and decremented on each tick.
  - `ring` clears when the timer reaches 0.
- **Ring dismiss:** `ring` also clears on any `mode` or `inc` press. That press is consumed: no FSM advance and no increment.
- **Alarm disable:** `ring` clears in the cycle after `alarm_en` is sampled 0.
- **Simultaneous presses:** if `mode` and `inc` are pressed in the same cycle, `mode` wins and `inc` is dropped. If `ring`=1, the pair only dismisses the ring.

## Timing
- **Reset values:** clock 00:00:00, alarm 00:00, `setting`=00, `ring`=0, prescaler 0, ring timer 0. Reset acts immediately at any point, including mid-set or mid-ring.
- **Outputs:** all outputs are registered.
- **Press latency:** a press sampled at edge k takes effect at edge k, so outputs change after that edge.
- **First increment after reset:** the first seconds increment happens at the TICKS_PER_SEC-th edge after reset release.
- **Ring assertion:** `ring` rises at the same edge that writes the matching HH:MM:00.
- **Ring release:** with no dismiss, `ring` falls at the RING_SECS-th subsequent tick edge.

## Test plan
All scenarios use TICKS_PER_SEC=4 and RING_SECS=3.
1. **Counting:** release reset and run 240 cycles -> 00:01:00. Preload 23:59:59 via set mode and apply one more tick -> 00:00:00.
2. **Setting the clock:** `target_sel`=0; press mode, inc×3, mode, inc×61, mode -> `clockHour`=0x03, `clockMin`=0x01, `clockSec`=0x00, `setting`=00. Check that seconds do not advance while setting.
3. **Alarm ring:** alarm set to 00:01, `alarm_en`=1, start from 00:00:00 -> `ring`=1 at the edge writing 00:01:00. `ring` drops after 3 further ticks (12 cycles).
4. **Dismiss:** with `ring` active, one `inc` press -> `ring`=0 next edge, `alarmMin` unchanged, `setting`=00. Repeat with `mode`: same result, with `setting` staying 00.
5. **Alarm setting while running:** set the alarm hour from 23 with one inc -> `alarmHour`=0x00. Check that the clock keeps counting during the whole set sequence.
6. **Reset mid-operation:** assert `rst_n`=0 mid-SET_MIN and separately mid-ring -> all outputs return to their reset values immediately, without waiting for a clock edge. A button held high through reset release produces no press.
